// File: rtl/bcd_to_bin_serial.sv
// bcd_to_bin_serial
// Sequential packed-BCD to unsigned binary converter using reverse double-dabble.
// The {bcd, bin} working register shifts right one bit per cycle. After each
// shift, 3 is subtracted from every BCD digit that is now >= 8. After BIN_W
// shifts the bin field holds the binary value.
//
// Parameters:
//   DIGITS  number of BCD digits (1..4)
//   BIN_W   result width, ceil(log2(10^DIGITS)): 4/7/10/14
//
// Ports:
//   Clock   rising-edge clock
//   Resetn  synchronous active-low reset
//   Start   conversion request, sampled only in IDLE
//   Sign    (BCD_SIGN_EN only) sign of the request, sampled with BCD
//   BCD     packed BCD input, digit 0 in [3:0]
//   Busy    high while converting
//   Done    one-cycle pulse when Bin/Err are updated
//   Err     last request contained a digit > 9
//   Bin     result. BIN_W bits unsigned, or BIN_W+1 bits two's complement
//           when BCD_SIGN_EN is defined.
//
// Optional feature macro: BCD_SIGN_EN (adds the Sign input and a signed result).
//
// state | meaning
// IDLE  | waiting for Start; Bin/Err hold the last result
// CONV  | shifting/correcting, one bit per cycle, BIN_W cycles
// DONE  | result ready; Done and Bin/Err are updated on leaving this state

module bcd_to_bin_serial #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
`ifdef BCD_SIGN_EN
    input  logic                  Sign,
`endif
    input  logic [4*DIGITS-1:0]   BCD,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
`ifdef BCD_SIGN_EN
    output logic [BIN_W:0]        Bin
`else
    output logic [BIN_W-1:0]      Bin
`endif
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] work_shift;
    logic [CNT_W-1:0]  cnt;
    logic              err_pend;
    logic              bcd_ok;
`ifdef BCD_SIGN_EN
    logic              sign_q;
    logic [BIN_W:0]    mag;
`endif

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD[4*i +: 4] > 4'd9) begin
                bcd_ok = 1'b0;
            end
        end
    end

    // One reverse double-dabble step: shift, then correct each digit that
    // picked up a 1 in its MSB from the digit above (worth 8, should be 5).
    always_comb begin
        work_shift = work >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_shift[BIN_W + 4*i + 3]) begin
                work_shift[BIN_W + 4*i +: 4] = work_shift[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_SIGN_EN
    assign mag = {1'b0, work[BIN_W-1:0]};
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            work     <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            Bin      <= '0;
`ifdef BCD_SIGN_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
`ifdef BCD_SIGN_EN
                        sign_q <= Sign;
`endif
                        if (bcd_ok) begin
                            work     <= {BCD, {BIN_W{1'b0}}};
                            cnt      <= '0;
                            err_pend <= 1'b0;
                            Busy     <= 1'b1;
                            state    <= S_CONV;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_CONV: begin
                    work <= work_shift;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        Busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Done <= 1'b1;
                    Err  <= err_pend;
                    if (err_pend) begin
                        Bin <= '0;
                    end else begin
`ifdef BCD_SIGN_EN
                        // Negating a zero magnitude yields zero, so -0 needs no special case.
                        Bin <= sign_q ? (~mag + 1'b1) : mag;
`else
                        Bin <= work[BIN_W-1:0];
`endif
                    end
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
module tb_bcd_to_bin_serial;

`ifdef BCD_SIGN_EN
    localparam int OUT_W = 8;
`else
    localparam int OUT_W = 7;
`endif

    logic             clock;
    logic             resetn;
    logic             start;
    logic [7:0]       bcd;
    logic             busy;
    logic             done;
    logic             err;
    logic [OUT_W-1:0] bin;
`ifdef BCD_SIGN_EN
    logic             sign_in;
`endif

    int checks = 0;
    int passed = 0;

    bcd_to_bin_serial #(.DIGITS(2), .BIN_W(7)) dut (
        .Clock (clock),
        .Resetn(resetn),
        .Start (start),
`ifdef BCD_SIGN_EN
        .Sign  (sign_in),
`endif
        .BCD   (bcd),
        .Busy  (busy),
        .Done  (done),
        .Err   (err),
        .Bin   (bin)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one request and follow it until Done (bounded). Inputs change on
    // negedges; outputs are sampled on negedges.
    task automatic do_conv(input logic [7:0] b, input logic s,
                           output int edges, output int busy_cyc, output bit got);
        @(negedge clock);
        bcd   = b;
        start = 1'b1;
`ifdef BCD_SIGN_EN
        sign_in = s;
`else
        if (s) bcd = b;
`endif
        @(posedge clock);
        edges = 0; busy_cyc = 0; got = 1'b0;
        @(negedge clock);
        start = 1'b0;
        if (busy) busy_cyc++;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (busy) busy_cyc++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %0b expected 0", err); else passed++;
        checks++; if (bin !== '0) $display("FAIL reset_bin: got %0d expected 0", bin); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_convert_99;
        int e, bc; bit g;
        do_conv(8'h99, 1'b0, e, bc, g);
        checks++; if (g !== 1'b1) $display("FAIL c99_done_seen: got %0b expected 1", g); else passed++;
        checks++; if (e != 8) $display("FAIL c99_latency: got %0d expected 8", e); else passed++;
        checks++; if (bc != 7) $display("FAIL c99_busy_cycles: got %0d expected 7", bc); else passed++;
        checks++; if (bin !== OUT_W'(99)) $display("FAIL c99_bin: got %0d expected 99", bin); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL c99_err: got %0b expected 0", err); else passed++;
        @(negedge clock);
        checks++; if (done !== 1'b0) $display("FAIL c99_done_width: got %0b expected 0", done); else passed++;
    endtask

    task automatic test_values;
        logic [7:0] vin  [5] = '{8'h45, 8'h00, 8'h01, 8'h50, 8'h87};
        int         vexp [5] = '{45, 0, 1, 50, 87};
        int e, bc; bit g;
        for (int i = 0; i < 5; i++) begin
            do_conv(vin[i], 1'b0, e, bc, g);
            checks++;
            if (!g || bin !== OUT_W'(vexp[i]))
                $display("FAIL value_%02h: got %0d (done=%0b) expected %0d", vin[i], bin, g, vexp[i]);
            else passed++;
            if (i == 0) begin
                @(negedge clock); bcd = 8'h00;
                repeat (5) @(negedge clock);
                checks++; if (bin !== OUT_W'(45)) $display("FAIL value_hold45: got %0d expected 45", bin); else passed++;
            end
        end
    endtask

    task automatic test_invalid;
        int e, bc; bit g;
        do_conv(8'h3A, 1'b0, e, bc, g);
        checks++; if (!g || e != 1) $display("FAIL inv_latency: got %0d (done=%0b) expected 1", e, g); else passed++;
        checks++; if (bc != 0) $display("FAIL inv_busy: got %0d busy cycles expected 0", bc); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL inv_err: got %0b expected 1", err); else passed++;
        checks++; if (bin !== '0) $display("FAIL inv_bin: got %0d expected 0", bin); else passed++;
        do_conv(8'h10, 1'b0, e, bc, g);
        checks++; if (err !== 1'b0) $display("FAIL inv_clear_err: got %0b expected 0", err); else passed++;
        checks++; if (bin !== OUT_W'(10)) $display("FAIL inv_next_bin: got %0d expected 10", bin); else passed++;
        do_conv(8'hA0, 1'b0, e, bc, g);
        checks++; if (err !== 1'b1 || e != 1) $display("FAIL inv_upper_digit: got err=%0b lat=%0d expected err=1 lat=1", err, e); else passed++;
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        @(negedge clock); bcd = 8'h77; start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); bcd = 8'h12; start = 1'b1;
        if (done) ndone++;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        if (done) ndone++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        checks++; if (ndone != 1) $display("FAIL ignore_done_count: got %0d expected 1", ndone); else passed++;
        checks++; if (bin !== OUT_W'(77)) $display("FAIL ignore_bin: got %0d expected 77", bin); else passed++;
    endtask

    task automatic test_reset_abort;
        int ndone = 0;
        int e, bc; bit g;
        @(negedge clock); bcd = 8'h23; start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL abort_done: got %0b expected 0", done); else passed++;
        checks++; if (bin !== '0) $display("FAIL abort_bin: got %0d expected 0", bin); else passed++;
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); else passed++;
        do_conv(8'h36, 1'b0, e, bc, g);
        checks++; if (!g || e != 8 || bin !== OUT_W'(36))
            $display("FAIL abort_restart: got bin=%0d lat=%0d expected bin=36 lat=8", bin, e); else passed++;
    endtask

    task automatic test_back_to_back;
        int gap = 0;
        bit got1 = 1'b0, got2 = 1'b0;
        @(negedge clock); bcd = 8'h21; start = 1'b1;
        for (int i = 0; i < 20 && !got1; i++) begin
            @(negedge clock);
            if (done) got1 = 1'b1;
        end
        for (int i = 0; i < 20 && got1 && !got2; i++) begin
            @(negedge clock);
            gap++;
            if (done) got2 = 1'b1;
        end
        start = 1'b0;
        checks++; if (!got2 || gap != 9) $display("FAIL b2b_period: got %0d (done=%0b) expected 9", gap, got2); else passed++;
        checks++; if (bin !== OUT_W'(21)) $display("FAIL b2b_bin: got %0d expected 21", bin); else passed++;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_after: got busy=%0b expected 0", busy); else passed++;
    endtask

`ifdef BCD_SIGN_EN
    task automatic test_sign;
        int e, bc; bit g;
        do_conv(8'h45, 1'b1, e, bc, g);
        checks++; if (bin !== 8'b11010011) $display("FAIL sign_neg45: got %b expected 11010011", bin); else passed++;
        do_conv(8'h00, 1'b1, e, bc, g);
        checks++; if (bin !== 8'd0) $display("FAIL sign_neg0: got %b expected 0", bin); else passed++;
        do_conv(8'h45, 1'b0, e, bc, g);
        checks++; if (bin !== 8'd45) $display("FAIL sign_pos45: got %b expected 00101101", bin); else passed++;
        do_conv(8'h4B, 1'b1, e, bc, g);
        checks++; if (bin !== 8'd0 || err !== 1'b1) $display("FAIL sign_invalid: got %b err=%0b expected 0 err=1", bin, err); else passed++;
    endtask
`endif

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        bcd    = 8'h00;
`ifdef BCD_SIGN_EN
        sign_in = 1'b0;
`endif
        test_reset();
        test_convert_99();
        test_values();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef BCD_SIGN_EN
        test_sign();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
